// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-key FSM state encoding
// and the width of the per-key stability counter.
package key_pkg;

    // Width of the per-key tick counter; wide enough for STABLE_TICKS up to 15.
    localparam int KEY_CNT_W = 4;

    // Debounce state of one key channel.
    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_debounce_fsm.sv
// One debounce channel. It sees an already synchronised, normalised
// "pressed" sample and a one-cycle tick; it only moves on tick cycles.
// A new level is accepted after STABLE_TICKS consecutive tick samples that
// disagree with the current level; the level and the matching one-cycle
// pulse are registered on the same edge as the accepting transition.
module key_debounce_fsm #(
    parameter int STABLE_TICKS = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_pressed,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse
);
    import key_pkg::*;

    localparam logic [KEY_CNT_W-1:0] LAST_CNT = KEY_CNT_W'(STABLE_TICKS - 1);

    key_state_e           r_state;
    logic [KEY_CNT_W-1:0] r_cnt;
    logic                 r_level;
    logic                 r_press_pulse;
    logic                 r_release_pulse;

    // Debounce FSM, counter, level and pulses; pulses self-clear every cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= KEY_RELEASED;
            r_cnt           <= '0;
            r_level         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    KEY_RELEASED: begin
                        if (i_pressed) begin
                            r_state <= KEY_PRESS_WAIT;
                            r_cnt   <= KEY_CNT_W'(1);
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    KEY_PRESS_WAIT: begin
                        if (!i_pressed) begin
                            r_state <= KEY_RELEASED;
                            r_cnt   <= '0;
                        end else if (r_cnt == LAST_CNT) begin
                            r_state       <= KEY_PRESSED;
                            r_cnt         <= '0;
                            r_level       <= 1'b1;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    KEY_PRESSED: begin
                        if (!i_pressed) begin
                            r_state <= KEY_RELEASE_WAIT;
                            r_cnt   <= KEY_CNT_W'(1);
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    KEY_RELEASE_WAIT: begin
                        if (i_pressed) begin
                            r_state <= KEY_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == LAST_CNT) begin
                            r_state         <= KEY_RELEASED;
                            r_cnt           <= '0;
                            r_level         <= 1'b0;
                            r_release_pulse <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= KEY_RELEASED;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level         = r_level;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer. The divided slow clock is only sampled: it is
// synchronised, edge-detected and turned into a one-cycle tick in the i_clk
// domain. Raw keys are synchronised, normalised to "1 = pressed" and fed to
// one independent debounce channel each.
module key_debouncer #(
    parameter int N_KEYS       = 4,
    parameter int STABLE_TICKS = 3,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_slow_clk,
    input  logic [N_KEYS-1:0] i_key,
    output logic              o_tick,
    output logic [N_KEYS-1:0] o_key_level,
    output logic [N_KEYS-1:0] o_press_pulse,
    output logic [N_KEYS-1:0] o_release_pulse
);
    import key_pkg::*;

    // Raw level of an unpressed key; synchronisers start here so reset
    // never looks like a press.
    localparam logic [N_KEYS-1:0] KEY_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic              r_slow_meta;
    logic              r_slow_sync;
    logic              r_slow_prev;
    logic              r_tick;
    logic [N_KEYS-1:0] r_key_meta;
    logic [N_KEYS-1:0] r_key_sync;
    logic [N_KEYS-1:0] w_pressed;

    // Two-flop synchroniser for the slow clock, plus its delayed copy and the registered rising-edge tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_slow_meta <= 1'b0;
            r_slow_sync <= 1'b0;
            r_slow_prev <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_slow_meta <= i_slow_clk;
            r_slow_sync <= r_slow_meta;
            r_slow_prev <= r_slow_sync;
            r_tick      <= r_slow_sync & ~r_slow_prev;
        end
    end

    // Two-flop synchroniser for every raw key bit, resetting to the idle level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_key_meta <= KEY_IDLE;
            r_key_sync <= KEY_IDLE;
        end else begin
            r_key_meta <= i_key;
            r_key_sync <= r_key_meta;
        end
    end

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_key_sync : r_key_sync;
    assign o_tick    = r_tick;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_fsm #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_fsm (
            .i_clk           (i_clk),
            .i_reset         (i_reset),
            .i_tick          (r_tick),
            .i_pressed       (w_pressed[g]),
            .o_level         (o_key_level[g]),
            .o_press_pulse   (o_press_pulse[g]),
            .o_release_pulse (o_release_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer. The bench owns the slow clock and raises it once
// per "tick window"; keys are held constant across a window. A reference
// model keeps the history of per-tick pressed samples and flips a key's
// accepted level once its last STABLE_TICKS samples all disagree with it.
module tb_key_debouncer;
    localparam int N  = 4;
    localparam int ST = 3;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_slow_clk = 1'b0;
    logic [N-1:0] i_key = '1;
    logic         o_tick;
    logic [N-1:0] o_key_level;
    logic [N-1:0] o_press_pulse;
    logic [N-1:0] o_release_pulse;

    key_debouncer #(
        .N_KEYS       (N),
        .STABLE_TICKS (ST),
        .ACTIVE_LOW   (1)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_slow_clk      (i_slow_clk),
        .i_key           (i_key),
        .o_tick          (o_tick),
        .o_key_level     (o_key_level),
        .o_press_pulse   (o_press_pulse),
        .o_release_pulse (o_release_pulse)
    );

    // 50 MHz system clock.
    always #10 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus: which keys the "user" holds down (1 = pressed).
    logic [N-1:0] drv_pressed = '0;

    // Reference model state.
    logic [N-1:0] hist_q[$];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] exp_press, exp_rel;

    // Observations from the last tick window.
    int           obs_ticks, obs_tick_at, obs_press_cyc, obs_rel_cyc, obs_pulse_at;
    logic [N-1:0] obs_press_val, obs_rel_val, obs_level;
    logic         obs_overlap;

    // Model: record the sample seen at this tick, then accept any key whose
    // last ST samples all differ from its current level.
    task automatic model_tick(input logic [N-1:0] sample);
        logic all_diff;
        hist_q.push_back(sample);
        exp_press = '0;
        exp_rel   = '0;
        for (int k = 0; k < N; k++) begin
            if (hist_q.size() >= ST) begin
                all_diff = 1'b1;
                for (int j = hist_q.size() - ST; j < hist_q.size(); j++)
                    if (hist_q[j][k] == m_level[k]) all_diff = 1'b0;
                if (all_diff) begin
                    if (sample[k]) exp_press[k] = 1'b1;
                    else           exp_rel[k]   = 1'b1;
                    m_level[k] = sample[k];
                end
            end
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        m_level = '0;
    endtask

    // One slow-clock period with keys held at drv_pressed; records what the DUT did.
    task automatic run_tick();
        obs_ticks = 0; obs_tick_at = -1; obs_press_cyc = 0; obs_rel_cyc = 0; obs_pulse_at = -1;
        obs_press_val = '0; obs_rel_val = '0; obs_overlap = 1'b0;
        i_key = ~drv_pressed;
        @(negedge i_clk);
        i_slow_clk = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) i_slow_clk = 1'b0;
            @(negedge i_clk);
            if (o_tick) begin obs_ticks++; obs_tick_at = c; end
            if (o_press_pulse != '0) begin obs_press_cyc++; obs_press_val |= o_press_pulse; obs_pulse_at = c; end
            if (o_release_pulse != '0) begin obs_rel_cyc++; obs_rel_val |= o_release_pulse; obs_pulse_at = c; end
            if ((o_press_pulse & o_release_pulse) != '0) obs_overlap = 1'b1;
        end
        obs_level = o_key_level;
        model_tick(drv_pressed);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_tick, o_key_level, o_press_pulse, o_release_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tick=%b lvl=%b prs=%b rel=%b, want all 0", o_tick, o_key_level, o_press_pulse, o_release_pulse);
        end
        i_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_idle();
        drv_pressed = '0;
        for (int i = 0; i < 10; i++) begin
            run_tick();
            n_checks++;
            if (obs_ticks != 1) begin n_fail++; $display("FAIL idle_tick_count[%0d]: got %0d, want 1", i, obs_ticks); end
            n_checks++;
            if (obs_press_cyc != 0 || obs_rel_cyc != 0 || obs_level !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got prs_cyc=%0d rel_cyc=%0d lvl=%b, want 0 0 0000", i, obs_press_cyc, obs_rel_cyc, obs_level);
            end
        end
    endtask

    task automatic test_press();
        drv_pressed = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            run_tick();
            n_checks++;
            if (obs_press_cyc != (exp_press != '0 ? 1 : 0) || obs_press_val !== exp_press || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL press[%0d]: got cyc=%0d prs=%b lvl=%b, want prs=%b lvl=%b", i, obs_press_cyc, obs_press_val, obs_level, exp_press, m_level);
            end
            if (i == 2) begin
                n_checks++;
                if (obs_press_val !== 4'b0001 || obs_pulse_at != obs_tick_at + 1) begin
                    n_fail++;
                    $display("FAIL press_third_tick: got prs=%b at cycle %0d (tick %0d), want 0001 one cycle after tick", obs_press_val, obs_pulse_at, obs_tick_at);
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 8; i++) begin
            drv_pressed[1] = (i % 2 == 0);
            run_tick();
            n_checks++;
            if (obs_press_cyc != 0 || obs_rel_cyc != 0 || obs_level[1] !== 1'b0 || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL glitch[%0d]: got prs_cyc=%0d rel_cyc=%0d lvl=%b, want no pulses lvl=%b", i, obs_press_cyc, obs_rel_cyc, obs_level, m_level);
            end
        end
    endtask

    task automatic test_release();
        int rel_total = 0;
        drv_pressed = '0;
        for (int i = 0; i < 4; i++) begin
            run_tick();
            rel_total += obs_rel_cyc;
            n_checks++;
            if (obs_rel_val !== exp_rel || obs_press_cyc != 0 || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL release[%0d]: got rel=%b prs_cyc=%0d lvl=%b, want rel=%b lvl=%b", i, obs_rel_val, obs_press_cyc, obs_level, exp_rel, m_level);
            end
        end
        n_checks++;
        if (rel_total != 1 || o_key_level[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_single: got %0d release cycles lvl0=%b, want 1 and 0", rel_total, o_key_level[0]);
        end
    endtask

    task automatic test_simultaneous();
        drv_pressed = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_tick();
            n_checks++;
            if (obs_press_cyc != (exp_press != '0 ? 1 : 0) || obs_press_val !== exp_press || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL simultaneous[%0d]: got cyc=%0d prs=%b lvl=%b, want prs=%b lvl=%b", i, obs_press_cyc, obs_press_val, obs_level, exp_press, m_level);
            end
        end
        n_checks++;
        if (o_key_level !== 4'b1001) begin n_fail++; $display("FAIL simultaneous_level: got %b, want 1001", o_key_level); end
    endtask

    task automatic test_reset_mid_debounce();
        drv_pressed = 4'b1011;
        run_tick();
        // Key 1 is now mid-debounce; keys 0 and 3 are accepted as pressed.
        #3 i_reset = 1'b1;
        #1;
        n_checks++;
        if ({o_tick, o_key_level, o_press_pulse, o_release_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got tick=%b lvl=%b prs=%b rel=%b, want all 0", o_tick, o_key_level, o_press_pulse, o_release_pulse);
        end
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 5; i++) begin
            run_tick();
            n_checks++;
            if (obs_press_cyc != (exp_press != '0 ? 1 : 0) || obs_press_val !== exp_press || obs_rel_cyc != 0 || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL reset_repress[%0d]: got cyc=%0d prs=%b rel_cyc=%0d lvl=%b, want prs=%b lvl=%b", i, obs_press_cyc, obs_press_val, obs_rel_cyc, obs_level, exp_press, m_level);
            end
            if (i == 2) begin
                n_checks++;
                if (obs_press_val !== 4'b1011) begin n_fail++; $display("FAIL reset_third_tick: got prs=%b, want 1011", obs_press_val); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 3) == 0) drv_pressed[k] = ~drv_pressed[k];
            run_tick();
            n_checks++;
            if (obs_ticks != 1 || obs_overlap
                || obs_press_cyc != (exp_press != '0 ? 1 : 0) || obs_press_val !== exp_press
                || obs_rel_cyc != (exp_rel != '0 ? 1 : 0) || obs_rel_val !== exp_rel
                || obs_level !== m_level) begin
                n_fail++;
                $display("FAIL random[%0d]: got ticks=%0d ovl=%b prs=%b/%0d rel=%b/%0d lvl=%b, want prs=%b rel=%b lvl=%b",
                         i, obs_ticks, obs_overlap, obs_press_val, obs_press_cyc, obs_rel_val, obs_rel_cyc, obs_level,
                         exp_press, exp_rel, m_level);
            end
            n_checks++;
            if ((obs_press_cyc + obs_rel_cyc) != 0 && obs_pulse_at != obs_tick_at + 1) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got pulse at cycle %0d, tick at %0d, want tick+1", i, obs_pulse_at, obs_tick_at);
            end
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_idle();
        test_press();
        test_glitch();
        test_release();
        test_simultaneous();
        test_reset_mid_debounce();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Runaway guard.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter N_KEYS, 4, number of independent push-button channels (1..8).
REQ-002 SHALL have parameter STABLE_TICKS, 3, consecutive equal tick samples required to accept a new key state (2..15).
REQ-003 SHALL have parameter ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
REQ-004 SHALL have port i_clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_slow_clk  input  1  divided clock from the clock divider, used as a sample-rate reference only, never as a clock.
REQ-007 SHALL have port i_key  input  N_KEYS  raw asynchronous button inputs.
REQ-008 SHALL have port o_tick  output  1  one-i_clk-cycle pulse per i_slow_clk rising edge.
REQ-009 SHALL have port o_key_level  output  N_KEYS  debounced state, 1 = pressed.
REQ-010 SHALL have port o_press_pulse  output  N_KEYS  one-cycle pulse on accepted press.
REQ-011 SHALL have port o_release_pulse  output  N_KEYS  one-cycle pulse on accepted release.

Function
REQ-012 SHALL synchronise i_slow_clk and each i_key bit through two i_clk flops.
REQ-013 SHALL generate the tick when the synchronised slow clock is 1 and its registered previous value is 0; o_tick is that registered pulse, exactly 1 cycle wide.
REQ-014 SHALL normalise each synchronised key to "pressed" = ACTIVE_LOW ? ~sync : sync.
REQ-015 SHALL run one FSM per key with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and a 4-bit counter; FSM and counter advance only in cycles where the tick is high, otherwise hold.
REQ-016 SHALL transition on tick: RELEASED, sample pressed -> PRESS_WAIT, cnt=1; RELEASED, sample released -> stay, cnt=0.
REQ-017 SHALL transition on tick in PRESS_WAIT: sample released -> RELEASED, cnt=0; sample pressed and cnt==STABLE_TICKS-1 -> PRESSED, cnt=0; otherwise cnt+1.
REQ-018 SHALL apply REQ-016/017 symmetrically: PRESSED with released sample -> RELEASE_WAIT, cnt=1; RELEASE_WAIT returns to PRESSED on a pressed sample, or enters RELEASED when cnt==STABLE_TICKS-1.
REQ-019 SHALL update o_key_level on the same i_clk edge as the PRESS_WAIT->PRESSED or RELEASE_WAIT->RELEASED transition.
REQ-020 SHALL assert o_press_pulse/o_release_pulse for exactly that one cycle; press and release pulses of one key are never high together.
REQ-021 SHALL keep keys fully independent; simultaneous acceptances on several keys pulse in the same cycle.
REQ-022 SHALL reject any glitch shorter than STABLE_TICKS tick periods; acceptance latency is STABLE_TICKS ticks after the first tick sampling the new value, plus 2-3 i_clk synchroniser cycles.

Reset
REQ-023 SHALL, while i_reset=1, force all FSMs to RELEASED, counters to 0, o_tick, o_key_level, o_press_pulse and o_release_pulse to 0.
REQ-024 SHALL reset key synchroniser flops to the released level (ACTIVE_LOW ? 1 : 0) so no spurious press follows reset; slow-clock flops reset to 0.
REQ-025 SHALL discard any debounce in progress on reset; a held key needs STABLE_TICKS fresh ticks after reset release before its press pulse.

Structure
REQ-026 SHALL place the FSM state enum (key_state_e) and counter width constant in the shared package key_pkg.
REQ-027 SHALL implement the per-key FSM, counter and pulse logic as sub-module key_debounce_fsm, instantiated N_KEYS times via generate; tick generation and synchronisers stay in the top.

Verification
REQ-028 SHALL verify: reset, keys idle (all 1s) for 10 ticks -> all outputs 0, o_tick pulses once per slow-clock period.
REQ-029 SHALL verify: key0 held low 5 ticks -> o_press_pulse[0]=1 for one cycle at the 3rd tick, o_key_level[0]=1 thereafter.
REQ-030 SHALL verify: key1 toggled every tick for 8 ticks -> no pulses, o_key_level[1] stays 0.
REQ-031 SHALL verify: key0 pressed then released for 3 ticks -> single o_release_pulse[0], level returns to 0.
REQ-032 SHALL verify: keys 0 and 3 pressed in the same cycle -> o_press_pulse=4'b1001 in one cycle.
REQ-033 SHALL verify: reset asserted in PRESS_WAIT with key held -> outputs 0 immediately; after release, press pulse exactly 3 ticks later.
